// File: rtl/rca_seq_pkg.sv
// rtl/rca_seq_pkg.sv - shared state type, slice width and slice-count helper for the rca slice sequencer
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 4;

  function automatic int slice_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/rca_settle_timer.sv
// rtl/rca_settle_timer.sv - per-slice settle counter, pulses done on the last of SETTLE cycles
module rca_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] cnt;

  assign done = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || done) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rca_slice_sequencer.sv
// rtl/rca_slice_sequencer.sv - drives a shared 4-bit ripple adder slice-by-slice; RCA_SEQ_SUB_EN adds in_sub
module rca_slice_sequencer
  import rca_seq_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int NSLICE = slice_count(WIDTH);
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  state_e           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             carry_reg;
  logic             accept;
  logic             step_done;

  // Subtraction is A + ~B + 1, so it reuses the same slice datapath.
`ifdef RCA_SEQ_SUB_EN
  assign b_in   = in_sub ? ~in_b : in_b;
  assign cin_in = in_sub | in_cin;
`else
  assign b_in   = in_b;
  assign cin_in = in_cin;
`endif

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign out_cout  = out_valid & carry_reg;
  assign accept    = in_valid & in_ready;

  assign a_sh    = a_lat >> (SLICE_W * int'(idx));
  assign b_sh    = b_lat >> (SLICE_W * int'(idx));
  assign add_a   = busy ? a_sh[SLICE_W-1:0] : '0;
  assign add_b   = busy ? b_sh[SLICE_W-1:0] : '0;
  assign add_cin = busy & carry_reg;

  rca_settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .en   (busy),
    .done (step_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_lat     <= '0;
      b_lat     <= '0;
      carry_reg <= 1'b0;
      out_sum   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_lat     <= in_a;
            b_lat     <= b_in;
            carry_reg <= cin_in;
            idx       <= '0;
            out_sum   <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (step_done) begin
            out_sum[SLICE_W*int'(idx) +: SLICE_W] <= add_sum;
            carry_reg <= add_cout;
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_slice_sequencer.sv
// tb/tb_rca_slice_sequencer.sv - scoreboard bench with gate-delay ripple adders for 16-bit and 4-bit instances
module tb_rca_slice_sequencer;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy, add_cin;
  logic [W-1:0] in_a, in_b, out_sum;
  logic [3:0]   add_a, add_b;
  wire  [3:0]   add_sum;
  wire          add_cout;
  wire  [4:0]   c0;
`ifdef RCA_SEQ_SUB_EN
  logic         in_sub;
  logic         s_sub;
`endif

  logic       s_valid, s_ready, s_cin, s_ovalid, s_oready, s_cout, s_busy, s_acin;
  logic [3:0] s_a, s_b, s_sum, s_aa, s_ab;
  wire  [3:0] s_asum;
  wire        s_acout;
  wire  [4:0] c1;

  int vectors = 0;
  int miscompares = 0;
  logic [W:0] sb_q[$];
  logic [W:0] exp_v;

  rca_slice_sequencer #(.WIDTH(W), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef RCA_SEQ_SUB_EN
    .in_sub(in_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .busy(busy), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  rca_slice_sequencer #(.WIDTH(4), .SETTLE(1)) dut_small (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready),
    .in_a(s_a), .in_b(s_b), .in_cin(s_cin),
`ifdef RCA_SEQ_SUB_EN
    .in_sub(s_sub),
`endif
    .out_valid(s_ovalid), .out_ready(s_oready), .out_sum(s_sum), .out_cout(s_cout),
    .busy(s_busy), .add_a(s_aa), .add_b(s_ab), .add_cin(s_acin),
    .add_sum(s_asum), .add_cout(s_acout)
  );

  // Gate-level ripple chains, 1 ns per gate stage, well inside the 10 ns period.
  assign c0[0]    = add_cin;
  assign add_cout = c0[4];
  assign c1[0]    = s_acin;
  assign s_acout  = c1[4];
  for (genvar i = 0; i < 4; i++) begin : g_rca
    assign #1 add_sum[i] = add_a[i] ^ add_b[i] ^ c0[i];
    assign #1 c0[i+1]    = (add_a[i] & add_b[i]) | (c0[i] & (add_a[i] ^ add_b[i]));
    assign #1 s_asum[i]  = s_aa[i] ^ s_ab[i] ^ c1[i];
    assign #1 c1[i+1]    = (s_aa[i] & s_ab[i]) | (c1[i] & (s_aa[i] ^ s_ab[i]));
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
`ifdef RCA_SEQ_SUB_EN
    in_sub   = sub;
`endif
    if (sub) sb_q.push_back({1'b0, a} + {1'b0, ~b} + 17'd1);
    else     sb_q.push_back({1'b0, a} + {1'b0, b} + 17'(cin));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int edges, output int busy_cyc);
    edges = 0;
    busy_cyc = 0;
    while (!out_valid && edges < 100) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      edges++;
    end
    if (!out_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL out_valid_timeout: waited %0d cycles, required out_valid", edges);
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, busy, out_cout, add_cin} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 10000", {in_ready, out_valid, busy, out_cout, add_cin});
    end
    vectors++;
    if ({out_sum, add_a, add_b} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h required 0", {out_sum, add_a, add_b});
    end
    vectors++;
    if ({s_ready, s_ovalid, s_busy, s_sum, s_cout} !== 8'b1000_0000) begin
      miscompares++;
      $display("FAIL reset_small: got %b required 10000000", {s_ready, s_ovalid, s_busy, s_sum, s_cout});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int e, b;
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_valid(e, b);
    vectors++;
    if (e !== 8) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d required 8", e);
    end
    vectors++;
    if (b !== 8) begin
      miscompares++;
      $display("FAIL basic_busy: got %0d required 8", b);
    end
    exp_v = sb_q.pop_front();
    vectors++;
    if ({out_cout, out_sum} !== exp_v || exp_v !== 17'h05555) begin
      miscompares++;
      $display("FAIL basic_sum: got %h required %h", {out_cout, out_sum}, exp_v);
    end
    handoff();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_idle: got in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_carry_chain();
    int n = 0, ones = 0;
    logic first;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    first = add_cin;
    while (!out_valid && n < 100) begin
      if (busy && add_cin) ones++;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (first !== 1'b0 || ones !== 6) begin
      miscompares++;
      $display("FAIL carry_add_cin: got first=%b ones=%0d required first=0 ones=6", first, ones);
    end
    exp_v = sb_q.pop_front();
    vectors++;
    if ({out_cout, out_sum} !== exp_v) begin
      miscompares++;
      $display("FAIL carry_sum: got %h required %h", {out_cout, out_sum}, exp_v);
    end
    handoff();
  endtask

  task automatic test_backpressure();
    int e, b;
    send(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
    wait_valid(e, b);
    exp_v = sb_q.pop_front();
    in_a = 16'h0001;
    in_b = 16'h0001;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({out_valid, in_ready, out_cout, out_sum} !== {2'b10, exp_v}) begin
        miscompares++;
        $display("FAIL hold_%0d: got %h required %h", i, {out_valid, in_ready, out_cout, out_sum}, {2'b10, exp_v});
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    handoff();
    vectors++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL hold_release: got %b required 100", {in_ready, busy, out_valid});
    end
  endtask

  task automatic test_abort();
    int e, b;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    vectors++;
    if ({in_ready, busy, out_valid, add_a, out_sum} !== {3'b100, 20'h0}) begin
      miscompares++;
      $display("FAIL abort_state: got %h required %h", {in_ready, busy, out_valid, add_a, out_sum}, {3'b100, 20'h0});
    end
    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait_valid(e, b);
    exp_v = sb_q.pop_front();
    vectors++;
    if ({out_cout, out_sum} !== exp_v || exp_v !== 17'h00100) begin
      miscompares++;
      $display("FAIL abort_next: got %h required %h", {out_cout, out_sum}, exp_v);
    end
    handoff();
  endtask

`ifdef RCA_SEQ_SUB_EN
  task automatic test_sub();
    int e, b;
    logic [W:0] want[2] = '{17'h0FFFE, 17'h10002};
    logic [W-1:0] av[2] = '{16'h0005, 16'h0007};
    logic [W-1:0] bv[2] = '{16'h0007, 16'h0005};
    for (int k = 0; k < 2; k++) begin
      send(av[k], bv[k], 1'b0, 1'b1);
      wait_valid(e, b);
      exp_v = sb_q.pop_front();
      vectors++;
      if ({out_cout, out_sum} !== exp_v || exp_v !== want[k]) begin
        miscompares++;
        $display("FAIL sub_%0d: got %h required %h", k, {out_cout, out_sum}, want[k]);
      end
      handoff();
    end
    in_sub = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    int e, b;
    for (int k = 0; k < 6; k++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      wait_valid(e, b);
      exp_v = sb_q.pop_front();
      vectors++;
      if ({out_cout, out_sum} !== exp_v || e !== 8) begin
        miscompares++;
        $display("FAIL b2b_%0d: got %h lat %0d required %h lat 8", k, {out_cout, out_sum}, e, exp_v);
      end
      handoff();
    end
  endtask

  task automatic test_small();
    int e = 0;
    @(negedge clk);
    s_a = 4'hF;
    s_b = 4'h1;
    s_cin = 1'b1;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    while (!s_ovalid && e < 100) begin
      @(negedge clk);
      e++;
    end
    vectors++;
    if (e !== 1) begin
      miscompares++;
      $display("FAIL small_latency: got %0d required 1", e);
    end
    vectors++;
    if ({s_cout, s_sum} !== 5'h11) begin
      miscompares++;
      $display("FAIL small_sum: got %h required 11", {s_cout, s_sum});
    end
    s_oready = 1'b1;
    @(negedge clk);
    s_oready = 1'b0;
    vectors++;
    if ({s_ready, s_ovalid} !== 2'b10) begin
      miscompares++;
      $display("FAIL small_idle: got %b required 10", {s_ready, s_ovalid});
    end
  endtask

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    s_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_oready = 1'b0;
`ifdef RCA_SEQ_SUB_EN
    in_sub = 1'b0; s_sub = 1'b0;
`endif
    test_reset();
    test_basic();
    test_carry_chain();
    test_backpressure();
    test_abort();
`ifdef RCA_SEQ_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    test_small();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
